// File: rtl/ram_mp_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared types and helpers for the multi-port RAM (ram_mp) and its write
//   resolver. Holds the controller state encoding, the read-during-write mode
//   selectors and the byte-count helper used by the elaboration checks.
// ---------------------------------------------------------------------------
package ram_pkg;

    // Controller state: CLEAR sweeps the array, RUN serves port requests.
    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_RUN   = 1'b1
    } ram_state_t;

    // READ_MODE selectors for a read that hits a word written on the same edge.
    localparam int RAM_READ_FIRST  = 0;   // return the pre-edge word
    localparam int RAM_WRITE_FIRST = 1;   // return the resolved post-edge word

    // Number of byte lanes in one word.
    function automatic int nbytes(input int word_bits, input int byte_bits);
        return word_bits / byte_bits;
    endfunction

endpackage

// File: rtl/ram_mp_write_resolve.sv
// ---------------------------------------------------------------------------
// ram_write_resolve
//   Combinational arbitration of same-cycle writes from all ports.
//   For every byte lane, when several ports write the same address the lowest
//   port index keeps the lane and the others are masked off. Lanes that do
//   not overlap pass through untouched, so partial writes merge naturally.
// Ports
//   in_write_ena   [NUM_PORTS]            write request per port (already
//                                         qualified by run state and range)
//   in_byte_ena    [NUM_PORTS*NUM_BYTES]  byte lane enables, port-major
//   in_addr        [NUM_PORTS*ADDR_BITS]  address per port, port-major
//   out_lane_mask  [NUM_PORTS*NUM_BYTES]  lanes each port actually writes
//   out_collision  1                      some lane was claimed by >1 port
// ---------------------------------------------------------------------------
module ram_write_resolve
    import ram_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 3,
    parameter int NUM_BYTES = 1
) (
    input  logic [NUM_PORTS-1:0]           in_write_ena,
    input  logic [NUM_PORTS*NUM_BYTES-1:0] in_byte_ena,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] in_addr,
    output logic [NUM_PORTS*NUM_BYTES-1:0] out_lane_mask,
    output logic                           out_collision
);

    logic [NUM_PORTS*NUM_BYTES-1:0] w_req;

    // Raw lane requests before arbitration.
    always_comb begin
        w_req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                w_req[p*NUM_BYTES + b] = in_write_ena[p] & in_byte_ena[p*NUM_BYTES + b];
            end
        end
    end

    // A lane is dropped if any lower-indexed port claims the same address+lane.
    always_comb begin
        out_lane_mask = w_req;
        out_collision = 1'b0;
        for (int p = 1; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                for (int q = 0; q < p; q++) begin
                    if (w_req[p*NUM_BYTES + b] && w_req[q*NUM_BYTES + b] &&
                        (in_addr[p*ADDR_BITS +: ADDR_BITS] == in_addr[q*ADDR_BITS +: ADDR_BITS])) begin
                        out_lane_mask[p*NUM_BYTES + b] = 1'b0;
                        out_collision                  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ram_mp.sv
// ---------------------------------------------------------------------------
// ram_mp
//   Multi-port synchronous RAM with per-byte write enables, lowest-port-wins
//   collision resolution and selectable read-during-write behaviour. After
//   reset, or on in_clear, a sequential engine writes CLEAR_WORD to every word
//   (one per cycle) so the array itself needs no reset and maps onto block RAM.
//
//   Request/result semantics: a read is a one-cycle request (in_read_ena high
//   for one clock, no back-pressure). Exactly one cycle of out_valid answers
//   it, 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1). While
//   out_busy is high every request is dropped and never answered.
// Ports
//   in_clk, in_rst   clock; asynchronous active-high reset
//   in_clear         pulse in RUN starts a sequential clear
//   out_busy         high while the clear engine owns the array
//   in_read_ena      [NUM_PORTS]            read request per port
//   in_write_ena     [NUM_PORTS]            write request per port
//   in_byte_ena      [NUM_PORTS*NUM_BYTES]  byte lane enables, port-major
//   in_addr          [NUM_PORTS*ADDR_BITS]  address per port, port-major
//   in_data          [NUM_PORTS*WORD_BITS]  write data per port, port-major
//   out_data         [NUM_PORTS*WORD_BITS]  read data, zero when not valid
//   out_valid        [NUM_PORTS]            out_data carries a read result
//   out_collision    1-cycle pulse after overlapping write lanes were resolved
//   out_dbg_state    controller state (0 = CLEAR, 1 = RUN)
// ---------------------------------------------------------------------------
module ram_mp
    import ram_pkg::*;
#(
    parameter int                  NUM_PORTS  = 2,
    parameter int                  ADDR_BITS  = 3,
    parameter int                  WORD_BITS  = 8,
    parameter int                  BYTE_BITS  = 8,
    parameter int                  NUM_WORDS  = 2**ADDR_BITS,
    parameter int                  READ_MODE  = RAM_READ_FIRST,
    parameter int                  OUT_REG    = 0,
    parameter logic [WORD_BITS-1:0] CLEAR_WORD = '0
) (
    input  logic                                                    in_clk,
    input  logic                                                    in_rst,
    input  logic                                                    in_clear,
    output logic                                                    out_busy,
    input  logic [NUM_PORTS-1:0]                                    in_read_ena,
    input  logic [NUM_PORTS-1:0]                                    in_write_ena,
    input  logic [NUM_PORTS*nbytes(WORD_BITS, BYTE_BITS)-1:0]       in_byte_ena,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]                          in_addr,
    input  logic [NUM_PORTS*WORD_BITS-1:0]                          in_data,
    output logic [NUM_PORTS*WORD_BITS-1:0]                          out_data,
    output logic [NUM_PORTS-1:0]                                    out_valid,
    output logic                                                    out_collision,
    output logic                                                    out_dbg_state
);

    localparam int NUM_BYTES = nbytes(WORD_BITS, BYTE_BITS);

    // Elaboration-time parameter sanity.
    if (NUM_BYTES * BYTE_BITS != WORD_BITS) begin : g_bad_word
        $error("ram_mp: WORD_BITS must be a multiple of BYTE_BITS");
    end
    if (NUM_WORDS > 2**ADDR_BITS) begin : g_bad_depth
        $error("ram_mp: NUM_WORDS exceeds the address space");
    end
    if (NUM_PORTS < 1) begin : g_bad_ports
        $error("ram_mp: NUM_PORTS must be at least 1");
    end

    ram_state_t                     r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]           r_cnt, w_cnt_nxt;
    logic                           w_run;
    logic [NUM_PORTS-1:0]           w_in_range;
    logic [NUM_PORTS-1:0]           w_wr_ok;
    logic [NUM_PORTS-1:0]           w_rd_ok;
    logic [NUM_PORTS*NUM_BYTES-1:0] w_lane_mask;
    logic                           w_coll;
    logic [NUM_PORTS*WORD_BITS-1:0] w_rd_word;
    logic [NUM_PORTS-1:0]           r_v1;
    logic [NUM_PORTS*WORD_BITS-1:0] r_d1;
    logic                           r_coll;
    logic [WORD_BITS-1:0]           r_mem [NUM_WORDS];

    // ---------------- controller FSM ----------------
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= RAM_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RAM_CLEAR: begin
                // in_clear is ignored here; the sweep always runs to the end.
                if (int'(r_cnt) == NUM_WORDS - 1) begin
                    w_state_nxt = RAM_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RAM_RUN: begin
                if (in_clear) begin
                    w_state_nxt = RAM_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RAM_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_run         = (r_state == RAM_RUN);
    assign out_busy      = ~w_run;
    assign out_dbg_state = r_state;

    // ---------------- request qualification ----------------
    always_comb begin
        w_in_range = '0;
        w_wr_ok    = '0;
        w_rd_ok    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_in_range[p] = (int'(in_addr[p*ADDR_BITS +: ADDR_BITS]) < NUM_WORDS);
            // Out-of-range writes vanish before arbitration, so they can
            // neither collide nor shadow a legal write.
            w_wr_ok[p]    = w_run & in_write_ena[p] & w_in_range[p];
            // Out-of-range reads are still answered (with zero data).
            w_rd_ok[p]    = w_run & in_read_ena[p];
        end
    end

    ram_write_resolve #(
        .NUM_PORTS (NUM_PORTS),
        .ADDR_BITS (ADDR_BITS),
        .NUM_BYTES (NUM_BYTES)
    ) u_resolve (
        .in_write_ena  (w_wr_ok),
        .in_byte_ena   (in_byte_ena),
        .in_addr       (in_addr),
        .out_lane_mask (w_lane_mask),
        .out_collision (w_coll)
    );

    // ---------------- array ----------------
    // No reset on the array: contents are defined by the clear sweep.
    always_ff @(posedge in_clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= CLEAR_WORD;
        end else begin
            // Resolved lane masks are disjoint per address, so order is irrelevant.
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (w_lane_mask[p*NUM_BYTES + b]) begin
                        r_mem[in_addr[p*ADDR_BITS +: ADDR_BITS]][b*BYTE_BITS +: BYTE_BITS] <=
                            in_data[p*WORD_BITS + b*BYTE_BITS +: BYTE_BITS];
                    end
                end
            end
        end
    end

    // Word presented to each read port. Write-first overlays the lanes that
    // the resolver lets through for this address, giving the merged word.
    always_comb begin
        w_rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_in_range[p]) begin
                w_rd_word[p*WORD_BITS +: WORD_BITS] = r_mem[in_addr[p*ADDR_BITS +: ADDR_BITS]];
            end
            if (READ_MODE == RAM_WRITE_FIRST) begin
                for (int q = 0; q < NUM_PORTS; q++) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (w_lane_mask[q*NUM_BYTES + b] &&
                            (in_addr[q*ADDR_BITS +: ADDR_BITS] == in_addr[p*ADDR_BITS +: ADDR_BITS])) begin
                            w_rd_word[p*WORD_BITS + b*BYTE_BITS +: BYTE_BITS] =
                                in_data[q*WORD_BITS + b*BYTE_BITS +: BYTE_BITS];
                        end
                    end
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_v1   <= '0;
            r_d1   <= '0;
            r_coll <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_v1[p]                        <= w_rd_ok[p];
                r_d1[p*WORD_BITS +: WORD_BITS] <= w_rd_ok[p] ? w_rd_word[p*WORD_BITS +: WORD_BITS]
                                                             : '0;
            end
            r_coll <= w_coll;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_PORTS-1:0]           r_v2;
        logic [NUM_PORTS*WORD_BITS-1:0] r_d2;
        always_ff @(posedge in_clk or posedge in_rst) begin
            if (in_rst) begin
                r_v2 <= '0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                r_d2 <= r_d1;
            end
        end
        assign out_valid = r_v2;
        assign out_data  = r_d2;
    end else begin : g_out_direct
        assign out_valid = r_v1;
        assign out_data  = r_d1;
    end

    assign out_collision = r_coll;

endmodule

// File: tb/tb_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_ram_mp
//   Three ram_mp instances share one stimulus stream:
//     u_a : 8 words, read-first,  1-cycle latency
//     u_b : 8 words, write-first, 2-cycle latency
//     u_c : 6 words, read-first,  1-cycle latency
//   Reads push {due_cycle, data} per instance/port; a negedge monitor pops and
//   compares when out_valid appears.
// ---------------------------------------------------------------------------
module tb_ram_mp;

  localparam int WB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        clear = 1'b0;
  logic [1:0]  re    = '0;
  logic [1:0]  we    = '0;
  logic [3:0]  be    = '0;
  logic [5:0]  addr  = '0;
  logic [31:0] wdata = '0;

  logic        busy_a, busy_b, busy_c;
  logic [31:0] data_a, data_b, data_c;
  logic [1:0]  valid_a, valid_b, valid_c;
  logic        coll_a, coll_b, coll_c;
  logic        st_a, st_b, st_c;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[6][$];   // index dut*2+port, entry {due_cycle, data}

  ram_mp #(.WORD_BITS(16), .BYTE_BITS(8)) u_a (
    .in_clk(clk), .in_rst(rst), .in_clear(clear), .out_busy(busy_a),
    .in_read_ena(re), .in_write_ena(we), .in_byte_ena(be), .in_addr(addr),
    .in_data(wdata), .out_data(data_a), .out_valid(valid_a),
    .out_collision(coll_a), .out_dbg_state(st_a));

  ram_mp #(.WORD_BITS(16), .BYTE_BITS(8), .READ_MODE(1), .OUT_REG(1)) u_b (
    .in_clk(clk), .in_rst(rst), .in_clear(clear), .out_busy(busy_b),
    .in_read_ena(re), .in_write_ena(we), .in_byte_ena(be), .in_addr(addr),
    .in_data(wdata), .out_data(data_b), .out_valid(valid_b),
    .out_collision(coll_b), .out_dbg_state(st_b));

  ram_mp #(.WORD_BITS(16), .BYTE_BITS(8), .NUM_WORDS(6)) u_c (
    .in_clk(clk), .in_rst(rst), .in_clear(clear), .out_busy(busy_c),
    .in_read_ena(re), .in_write_ena(we), .in_byte_ena(be), .in_addr(addr),
    .in_data(wdata), .out_data(data_c), .out_valid(valid_c),
    .out_collision(coll_c), .out_dbg_state(st_c));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clear = 1'b0; re = '0; we = '0; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_wr(input int p, input logic [1:0] lanes, input logic [2:0] a, input logic [15:0] d);
    we[p]          = 1'b1;
    be[p*2 +: 2]   = lanes;
    addr[p*3 +: 3] = a;
    wdata[p*16 +: 16] = d;
  endtask

  task automatic push_exp(input int d, input int p, input logic [15:0] v, input int lat);
    exp_q[d*2 + p].push_back({32'(cyc + lat), v});
  endtask

  // Read on port p; ea/eb/ec are the words expected from u_a/u_b/u_c.
  task automatic set_rd(input int p, input logic [2:0] a,
                        input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
    re[p]          = 1'b1;
    addr[p*3 +: 3] = a;
    push_exp(0, p, ea, 1);
    push_exp(1, p, eb, 2);
    push_exp(2, p, ec, 1);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic chk_port(input int idx, input logic v, input logic [15:0] d);
    logic [47:0] e;
    if (v === 1'b1) begin
      if (exp_q[idx].size() == 0) begin
        n_checks++;
        assert (v === 1'b0) else begin
          n_fail++;
          $error("FAIL unexpected_valid q%0d got valid=%b data=%h exp no result", idx, v, d);
        end
      end else begin
        e = exp_q[idx].pop_front();
        n_checks++;
        assert (d === e[15:0]) else begin
          n_fail++;
          $error("FAIL read_data q%0d got=%h exp=%h", idx, d, e[15:0]);
        end
        n_checks++;
        assert (cyc === int'(e[47:16])) else begin
          n_fail++;
          $error("FAIL read_latency q%0d got_cycle=%0d exp_cycle=%0d", idx, cyc, int'(e[47:16]));
        end
      end
    end else begin
      n_checks++;
      assert (d === 16'h0000) else begin
        n_fail++;
        $error("FAIL idle_data q%0d got=%h exp=0000", idx, d);
      end
      if (exp_q[idx].size() != 0) begin
        e = exp_q[idx][0];
        if (int'(e[47:16]) <= cyc) begin
          void'(exp_q[idx].pop_front());
          n_checks++;
          assert (v === 1'b1) else begin
            n_fail++;
            $error("FAIL missing_valid q%0d got valid=%b exp=1 at cycle %0d", idx, v, cyc);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk_port(0, valid_a[0], data_a[15:0]);
    chk_port(1, valid_a[1], data_a[31:16]);
    chk_port(2, valid_b[0], data_b[15:0]);
    chk_port(3, valid_b[1], data_b[31:16]);
    chk_port(4, valid_c[0], data_c[15:0]);
    chk_port(5, valid_c[1], data_c[31:16]);
  end

  // Count busy samples over a fixed window; optional traffic must be dropped.
  task automatic busy_window(input bit traffic);
    int ca, cb, cc;
    ca = 0; cb = 0; cc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_a === 1'b1) ca++;
      if (busy_b === 1'b1) cb++;
      if (busy_c === 1'b1) cc++;
      idle_in();
      if (traffic && i < 8) begin
        set_wr(0, 2'b11, 3'(i), 16'h7700 + 16'(i));
        if (i < 6) begin
          set_wr(1, 2'b11, 3'(7 - i), 16'h8888);
          re[1] = 1'b1;
        end
      end
      tick();
    end
    idle_in();
    check("busy_len_a", ca, 8);
    check("busy_len_b", cb, 8);
    check("busy_len_c", cc, 6);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] mem6 [6];

  initial begin
    mem6[0] = 16'h0000; mem6[1] = 16'h0000; mem6[2] = 16'h5A34;
    mem6[3] = 16'h00CD; mem6[4] = 16'hBBAA; mem6[5] = 16'h1122;

    // Reset state
    idle_in();
    rst = 1'b1;
    tick(); tick();
    check("rst_busy_a", busy_a, 1);
    check("rst_busy_c", busy_c, 1);
    check("rst_state_a", st_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_data_a", data_a, 0);
    check("rst_coll_a", coll_a, 0);
    rst = 1'b0;
    busy_window(1'b0);
    check("run_state_a", st_a, 1);
    check("run_state_c", st_c, 1);

    // All words cleared
    for (int i = 0; i < 8; i++) begin
      idle_in();
      set_rd(0, 3'(i), 16'h0, 16'h0, 16'h0);
      set_rd(1, 3'(7 - i), 16'h0, 16'h0, 16'h0);
      tick();
    end
    idle_in(); tick(); tick(); tick();

    // Single-lane write
    set_wr(0, 2'b01, 3'd3, 16'hABCD); tick(); idle_in();
    set_rd(0, 3'd3, 16'h00CD, 16'h00CD, 16'h00CD); tick(); idle_in();
    tick(); tick();

    // Overlapping lanes: port 0 wins, collision pulse
    set_wr(0, 2'b11, 3'd5, 16'h1111);
    set_wr(1, 2'b10, 3'd5, 16'h2222);
    tick(); idle_in();
    check("coll_pulse_a", coll_a, 1);
    check("coll_pulse_b", coll_b, 1);
    check("coll_pulse_c", coll_c, 1);
    set_rd(0, 3'd5, 16'h1111, 16'h1111, 16'h1111);
    tick(); idle_in();
    check("coll_drop_a", coll_a, 0);

    // Disjoint lanes merge, no collision
    set_wr(0, 2'b10, 3'd5, 16'h1111);
    set_wr(1, 2'b01, 3'd5, 16'h2222);
    tick(); idle_in();
    check("merge_coll_a", coll_a, 0);
    check("merge_coll_b", coll_b, 0);
    set_rd(1, 3'd5, 16'h1122, 16'h1122, 16'h1122);
    tick(); idle_in(); tick(); tick();

    // Read-during-write, other port
    set_wr(0, 2'b11, 3'd2, 16'h0F0F); tick(); idle_in();
    set_wr(0, 2'b11, 3'd2, 16'h5A5A);
    set_rd(1, 3'd2, 16'h0F0F, 16'h5A5A, 16'h0F0F);
    tick(); idle_in();
    set_rd(1, 3'd2, 16'h5A5A, 16'h5A5A, 16'h5A5A);
    tick(); idle_in();

    // Read-during-write, same port, partial lane
    set_wr(0, 2'b01, 3'd2, 16'h1234);
    set_rd(0, 3'd2, 16'h5A5A, 16'h5A34, 16'h5A5A);
    tick(); idle_in();

    // Write-first sees the merged, resolved word
    set_wr(0, 2'b01, 3'd4, 16'hAAAA);
    set_wr(1, 2'b11, 3'd4, 16'hBBBB);
    set_rd(0, 3'd4, 16'h0000, 16'hBBAA, 16'h0000);
    tick(); idle_in();
    check("rdw_coll_b", coll_b, 1);
    set_rd(1, 3'd4, 16'hBBAA, 16'hBBAA, 16'hBBAA);
    tick(); idle_in(); tick(); tick();

    // Out-of-range address on the 6-word instance
    set_wr(0, 2'b11, 3'd7, 16'hFFFF); tick(); idle_in();
    set_rd(0, 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000); tick(); idle_in();
    for (int i = 0; i < 6; i++) begin
      idle_in();
      set_rd(1, 3'(i), mem6[i], mem6[i], mem6[i]);
      tick();
    end
    idle_in(); tick(); tick(); tick();

    // Clear in RUN with traffic: requests dropped, array zeroed
    clear = 1'b1;
    set_wr(0, 2'b11, 3'd0, 16'hDEAD);
    tick();
    busy_window(1'b1);
    for (int i = 0; i < 8; i++) begin
      idle_in();
      set_rd(0, 3'(i), 16'h0, 16'h0, 16'h0);
      tick();
    end
    idle_in(); tick(); tick(); tick();

    // Reset while a read is in flight: results flushed
    re[0] = 1'b1; addr[2:0] = 3'd3;
    tick(); idle_in();
    rst = 1'b1;
    tick();
    check("rst_flush_valid_a", valid_a, 0);
    check("rst_flush_valid_b", valid_b, 0);
    check("rst_mid_read_busy_b", busy_b, 1);
    rst = 1'b0;
    busy_window(1'b0);

    // Reset at clear cycle 4: sweep restarts from the beginning
    clear = 1'b1; tick(); idle_in();
    tick(); tick(); tick();
    check("mid_clear_busy_a", busy_a, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_clear_state_a", st_a, 0);
    rst = 1'b0;
    busy_window(1'b0);
    set_rd(0, 3'd5, 16'h0, 16'h0, 16'h0);
    set_rd(1, 3'd2, 16'h0, 16'h0, 16'h0);
    tick(); idle_in();
    tick(); tick(); tick(); tick();

    // ---------------- final report ----------------
    for (int i = 0; i < 6; i++) begin
      check($sformatf("queue_drained_q%0d", i), exp_q[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
